countdown_sequencer: RTL and testbench

- Controller that sequences a four-digit BCD down-count, MM:SS, digits [15:12]=min tens, [11:8]=min units, [7:4]=sec tens, [3:0]=sec units.
- It owns the prescaler, the per-digit borrow chain, and a load/run/pause/done state machine.
- It replaces the ripple-clocked digit counters with one synchronous domain and drives the display and alarm logic of the timer.

---
 rtl/countdown_pkg.sv | 28 ++
 rtl/bcd_down_digit.sv | 39 +++
 rtl/countdown_sequencer.sv | 167 ++++++++++++++++
 tb/tb_countdown_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types, digit limits and preset validation for the MM:SS countdown sequencer.
package countdown_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BCD_W   = 16;

   localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
   localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // A preset is usable only if it is a well-formed MM:SS value within the minutes limit.
   function automatic logic bcd_valid(input logic [BCD_W-1:0]   v,
                                      input logic [DIGIT_W-1:0] min_tens_max);
      return (v[3:0]   <= DIGIT_MAX)    &&
             (v[7:4]   <= SEC_TENS_MAX) &&
             (v[11:8]  <= DIGIT_MAX)    &&
             (v[15:12] <= DIGIT_MAX)    &&
             (v[15:12] <= min_tens_max);
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: parallel load, decrement on en, wraps 0 -> MAX with borrow.
module bcd_down_digit
   import countdown_pkg::*;
#(
   parameter int unsigned MAX = 9
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic               load,
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q,
   output logic               borrow_out
);

   logic [DIGIT_W-1:0] q_q;
   logic [DIGIT_W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = d;
      end else if (en) begin
         q_d = (q_q == '0) ? DIGIT_W'(MAX) : q_q - DIGIT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q          = q_q;
   assign borrow_out = en & (q_q == '0);

endmodule

// File: rtl/countdown_sequencer.sv
// MM:SS BCD countdown controller: prescaler, four-digit borrow chain and load/run/pause/done FSM.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the last legal preset on reaching 0000 and keep running.
module countdown_sequencer
   import countdown_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 50_000_000,
   parameter int unsigned MIN_TENS_MAX = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [BCD_W-1:0] preset,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   output logic [BCD_W-1:0] digits,
   output logic             running,
   output logic             done,
   output logic             load_err
);

   localparam int unsigned        PRESC_W    = $clog2(CLK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

   state_e             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               running_q, running_d;
   logic               done_q, done_d;
   logic               load_err_q, load_err_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [BCD_W-1:0]   shadow_q, shadow_d;
`endif

   logic               count_ok_c;
   logic               tick_c;
   logic               dig_load_c;
   logic [BCD_W-1:0]   dig_val_c;
   logic [BCD_W-1:0]   digits_c;
   logic [3:0]         borrow_c;
   logic               done_pulse_c;

   // Counting proceeds in RUN unless clear or an effective pause takes the cycle.
   always_comb begin
      count_ok_c = (state_q == ST_RUN) && !clear && !(pause && !load);
      tick_c     = count_ok_c && (presc_q == PRESC_LAST);
   end

   bcd_down_digit #(.MAX(int'(DIGIT_MAX))) u_sec_units (
      .clock(clock), .reset(reset), .en(tick_c), .load(dig_load_c),
      .d(dig_val_c[3:0]), .q(digits_c[3:0]), .borrow_out(borrow_c[0])
   );

   bcd_down_digit #(.MAX(int'(SEC_TENS_MAX))) u_sec_tens (
      .clock(clock), .reset(reset), .en(borrow_c[0]), .load(dig_load_c),
      .d(dig_val_c[7:4]), .q(digits_c[7:4]), .borrow_out(borrow_c[1])
   );

   bcd_down_digit #(.MAX(int'(DIGIT_MAX))) u_min_units (
      .clock(clock), .reset(reset), .en(borrow_c[1]), .load(dig_load_c),
      .d(dig_val_c[11:8]), .q(digits_c[11:8]), .borrow_out(borrow_c[2])
   );

   bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clock(clock), .reset(reset), .en(borrow_c[2]), .load(dig_load_c),
      .d(dig_val_c[15:12]), .q(digits_c[15:12]), .borrow_out(borrow_c[3])
   );

   // Command decode (clear > load > pause > start), then prescaler and countdown.
   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      dig_load_c   = 1'b0;
      dig_val_c    = '0;
      load_err_d   = 1'b0;
      done_pulse_c = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      shadow_d     = shadow_q;
`endif

      if (clear) begin
         state_d    = ST_IDLE;
         dig_load_c = 1'b1;
         presc_d    = '0;
      end else if (load) begin
         if (state_q != ST_RUN) begin
            if (bcd_valid(preset, DIGIT_W'(MIN_TENS_MAX))) begin
               state_d    = ST_READY;
               dig_load_c = 1'b1;
               dig_val_c  = preset;
               presc_d    = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               shadow_d   = preset;
`endif
            end else begin
               load_err_d = 1'b1;
            end
         end
      end else if (pause) begin
         if (state_q == ST_RUN) begin
            state_d = ST_PAUSE;
         end
      end else if (start) begin
         if (state_q == ST_READY || state_q == ST_PAUSE) begin
            state_d = (digits_c == '0) ? ST_DONE : ST_RUN;
         end
      end

      if (count_ok_c) begin
         presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         // Digits sat at 0000 for the pulse cycle; restart from the shadow preset.
         if (digits_c == '0) begin
            dig_load_c = 1'b1;
            dig_val_c  = shadow_q;
         end
`endif
         if (tick_c && digits_c == BCD_W'(16'h0001)) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (shadow_q == '0) begin
               state_d = ST_DONE;
            end else begin
               done_pulse_c = 1'b1;
            end
`else
            state_d = ST_DONE;
`endif
         end
         // Guard against a wrap from 0000 to 99:59; should never occur.
         if (borrow_c[3]) begin
            state_d    = ST_DONE;
            dig_load_c = 1'b1;
            dig_val_c  = '0;
         end
      end

      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE) | done_pulse_c;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         shadow_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         running_q  <= running_d;
         done_q     <= done_d;
         load_err_q <= load_err_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         shadow_q   <= shadow_d;
`endif
      end
   end

   assign digits   = digits_c;
   assign running  = running_q;
   assign done     = done_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios plus random commands vs. a seconds-based model.
module tb_countdown_sequencer;

   localparam int unsigned CLK_DIV = 4;
   localparam int M_IDLE  = 0;
   localparam int M_READY = 1;
   localparam int M_RUN   = 2;
   localparam int M_PAUSE = 3;
   localparam int M_DONE  = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        load, start, pause, clear;
   logic [15:0] preset;
   logic [15:0] digits;
   logic        running, done, load_err;

   int errors = 0;
   int checks = 0;

   // Reference model: remaining time held as whole seconds.
   int m_mode, m_secs, m_phase, m_err, m_pulse, m_shadow;

   countdown_sequencer #(.CLK_DIV(CLK_DIV)) dut (
      .clock(clock), .reset(reset), .load(load), .preset(preset),
      .start(start), .pause(pause), .clear(clear),
      .digits(digits), .running(running), .done(done), .load_err(load_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m = s / 60;
      int r = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
   endfunction

   function automatic bit preset_ok(input logic [15:0] p);
      return (p[3:0] <= 9) && (p[7:4] <= 5) && (p[11:8] <= 9) && (p[15:12] <= 9);
   endfunction

   function automatic int bcd_secs(input logic [15:0] p);
      return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_err = 0; m_pulse = 0; m_shadow = 0;
   endtask

   task automatic model_step();
      int  old_mode = m_mode;
      bit  counting = (old_mode == M_RUN) && !clear && !(pause && !load);
      m_err   = 0;
      m_pulse = 0;
      if (clear) begin
         m_mode = M_IDLE; m_secs = 0; m_phase = 0;
      end else if (load) begin
         if (old_mode != M_RUN) begin
            if (preset_ok(preset)) begin
               m_secs = bcd_secs(preset); m_phase = 0; m_mode = M_READY; m_shadow = m_secs;
            end else begin
               m_err = 1;
            end
         end
      end else if (pause) begin
         if (old_mode == M_RUN) m_mode = M_PAUSE;
      end else if (start) begin
         if (old_mode == M_READY || old_mode == M_PAUSE)
            m_mode = (m_secs == 0) ? M_DONE : M_RUN;
      end
      if (counting) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         if (m_secs == 0) m_secs = m_shadow;
`endif
         m_phase++;
         if (m_phase == int'(CLK_DIV)) begin
            m_phase = 0;
            m_secs--;
            if (m_secs == 0) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               if (m_shadow == 0) m_mode = M_DONE;
               else m_pulse = 1;
`else
               m_mode = M_DONE;
`endif
            end
         end
      end
   endtask

   task automatic compare_all();
      check("digits",   32'(digits),   32'(to_bcd(m_secs)));
      check("running",  32'(running),  32'(m_mode == M_RUN));
      check("done",     32'(done),     32'((m_mode == M_DONE) || (m_pulse != 0)));
      check("load_err", 32'(load_err), 32'(m_err));
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] p);
      load = 1'b1; preset = p; step(); load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   initial begin
      int k;
      reset  = 1'b1;
      preset = '0;
      idle_inputs();
      model_reset();
      #1;
      compare_all();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Full 01:00 countdown.
      do_load(16'h0100);
      do_start();
      repeat (4) step();
      check("first_tick", 32'(digits), 32'h0059);
      repeat (236) step();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      check("end_digits", 32'(digits), 32'h0000);
      check("end_done", 32'(done), 32'h1);
      check("end_running", 32'(running), 32'h0);
`endif

      // Pause mid-count and resume; done must land after the paused interval.
      do_load(16'h0005);
      do_start();
      k = 0;
      while (!done && k < 80) begin
         k++;
         pause = (k == 6);
         start = (k == 16);
         step();
      end
      idle_inputs();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      check("pause_done_step", 32'(k), 32'd31);
`endif

      // Illegal presets are rejected without disturbing state.
      do_clear();
      do_load(16'h0060);
      check("err_060_pulse", 32'(load_err), 32'h1);
      check("err_060_digits", 32'(digits), 32'h0000);
      step();
      check("err_060_clear", 32'(load_err), 32'h0);
      do_load(16'h0A00);
      check("err_A00_pulse", 32'(load_err), 32'h1);

      // Zero preset goes straight to DONE.
      do_load(16'h0000);
      do_start();
      check("zero_done", 32'(done), 32'h1);
      repeat (6) step();

      // clear beats load while running.
      do_load(16'h1000);
      do_start();
      repeat (3) step();
      load = 1'b1; clear = 1'b1; preset = 16'h0030;
      step();
      idle_inputs();
      check("clr_load_digits", 32'(digits), 32'h0000);
      check("clr_load_running", 32'(running), 32'h0);

      // Borrow across every digit, then asynchronous reset mid-count.
      do_load(16'h1000);
      do_start();
      repeat (4) step();
      check("borrow_chain", 32'(digits), 32'h0959);
      repeat (2) step();
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      check("async_rst_running", 32'(running), 32'h0);
      #1 reset = 1'b0;

      // Random command mix.
      for (int i = 0; i < 3000; i++) begin
         clear = ($urandom % 97) == 0;
         load  = ($urandom % 13) == 0;
         pause = ($urandom % 11) == 0;
         start = ($urandom % 6) == 0;
         if (($urandom % 4) == 0) preset = 16'($urandom);
         else preset = {4'h0, 4'($urandom % 2), 4'($urandom % 6), 4'($urandom % 10)};
         step();
      end
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
